dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the single-cycle RISC-V core and a DMA/loader requester.
- Sequences each access over a multi-cycle memory. Asserts core_stall to freeze the core until its load or store completes.
- Sits between the core's MemWrite/DataAdr/WriteData interface and the data memory inside top.

Parameters:
- AW, 32, address width
- DW, 32, data width
- WAIT_CYCLES, 1, memory access cycles per transfer; legal values are 1..15
- STARVE_LIMIT, 4, consecutive core grants allowed while dma_req is pending before DMA is forced a grant

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low; 0 = reset asserted
- core_req  input  1  core memory access request (load or store)
- core_we  input  1  core store (1) or load (0)
- core_addr  input  AW  core byte address
- core_wdata  input  DW  core store data
- core_rdata  output  DW  core load data; valid when core_req=1 and core_stall=0
- core_stall  output  1  freeze core PC and register file
- dma_req  input  1  DMA request; held until dma_ack
- dma_we  input  1  DMA write enable
- dma_addr  input  AW  DMA address
- dma_wdata  input  DW  DMA write data
- dma_rdata  output  DW  DMA read data; valid when dma_ack=1
- dma_ack  output  1  one-cycle completion pulse
- mem_en  output  1  memory access enable
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data, valid on the last access cycle
- busy  output  1  high while an access is in progress

Behaviour:
- FSM states: IDLE, ACCESS. Owner register: CORE or DMA. 4-bit wait counter wcnt. Starvation counter scnt of width clog2(STARVE_LIMIT+1).
- Reset (reset=0, asynchronous): state=IDLE; mem_en, mem_we, mem_addr, mem_wdata, dma_ack, busy, wcnt and scnt all 0. Under reset, core_stall = core_req.
- Arbitration in IDLE, rising edge:
  - Only one requester active: grant it.
  - Both active: grant core, unless scnt==STARVE_LIMIT, in which case grant DMA.
  - On grant: latch we/addr/wdata of the winner into the mem_* registers, set owner, wcnt=WAIT_CYCLES-1, state=ACCESS.
- scnt update: increments (saturating) on each core grant made while dma_req=1. Clears on any DMA grant, and on any core grant made while dma_req=0.
- ACCESS:
  - mem_en=1 and busy=1.
  - If wcnt!=0, decrement wcnt.
  - If wcnt==0, this is the completion cycle. State returns to IDLE next edge, and mem_en/mem_we are cleared at that edge.
- Completion cycle outputs:
  - owner=CORE: core_stall=0.
  - owner=DMA: dma_ack=1.
  - core_rdata and dma_rdata = mem_rdata, combinational passthrough. Outside the completion cycle their values are don't-care.
- core_stall = core_req AND NOT (state==ACCESS AND owner==CORE AND wcnt==0). This is combinational.
- Core access latency: 1 + WAIT_CYCLES cycles, with a one-cycle IDLE bubble between back-to-back accesses.
- A requester dropping its req mid-ACCESS does not abort the access. The transfer completes, and the ack/stall release is still generated.
- Requests arriving during ACCESS wait for IDLE.
- Reset asserted mid-ACCESS: immediate return to IDLE and mem_en=0. No ack is issued.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, add output ports:
  - stat_stall_cycles [31:0]: counts clk cycles with core_stall=1.
  - stat_dma_grants [15:0]: counts DMA grants.
  - Both counters saturate and clear on reset.
- When undefined, these ports and their logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum {IDLE, ACCESS}
  - owner enum {OWN_CORE, OWN_DMA}
  - WCNT_W=4
  - helper function for scnt width
- One natural sub-module, dmem_wait_timer: loadable down-counter that outputs a last_cycle flag. Instantiated once.

Test Plan:
- Core store, WAIT_CYCLES=1: core_req=1, we=1, addr=100, wdata=25 → core_stall=1 for 1 cycle; then mem_en=mem_we=1, mem_addr=100, mem_wdata=25 with core_stall=0 in the same cycle.
- Core load, WAIT_CYCLES=3, mem_rdata=0x0000_0019 → core_stall high for 3 cycles, low in the 4th cycle with core_rdata=0x19.
- Contention, STARVE_LIMIT=4: core_req and dma_req held continuously → grant order is CORE×4, DMA, CORE×4, DMA; dma_ack pulses once per DMA grant.
- DMA write to addr 96, data 7, core idle → mem_we=1, mem_addr=96 in ACCESS; dma_ack=1 for exactly 1 cycle; busy low afterwards.
- Reset pulled low in the middle of a WAIT_CYCLES=3 access → mem_en=0 and busy=0 immediately, no dma_ack. After release, a fresh request completes normally.
- With DMEM_ARB_STATS_EN defined: run the contention scenario for 10 grants → stat_dma_grants=2, and stat_stall_cycles equals the monitor's count of core_stall-high cycles.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing helpers for the data-memory arbiter.
// Optional statistics ports in dmem_arbiter are enabled by defining DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } arb_owner_e;

    localparam int WCNT_W = 4;

    // Starvation counter must hold STARVE_LIMIT itself; never narrower than one bit.
    function automatic int scnt_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dmem_wait_timer.sv
// Loadable down-counter that sequences the memory wait states of one transfer.
// last_cycle is high whenever the count has reached zero.
module dmem_wait_timer
    import dmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WCNT_W-1:0] load_val,
    input  logic              run,
    output logic              last_cycle
);

    logic [WCNT_W-1:0] cnt_q;
    logic [WCNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_cycle = (cnt_q == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the core and a DMA requester,
// stalling the core until its access completes. Define DMEM_ARB_STATS_EN for stall/grant counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]   stat_stall_cycles,
    output logic [15:0]   stat_dma_grants
`endif
);

    localparam int                SCNT_W    = scnt_width(STARVE_LIMIT);
    localparam logic [SCNT_W-1:0] SCNT_MAX  = SCNT_W'(STARVE_LIMIT);
    localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(WAIT_CYCLES - 1);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;

    logic grant_core;
    logic grant_dma;
    logic in_access;
    logic last_cycle;
    logic done;

    assign in_access = (state_q == ACCESS);
    assign done      = in_access && last_cycle;

    dmem_wait_timer u_wait_timer (
        .clk       (clk),
        .rst_n     (reset),
        .load      (grant_core || grant_dma),
        .load_val  (WCNT_LOAD),
        .run       (in_access),
        .last_cycle(last_cycle)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        scnt_d      = scnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_core  = 1'b0;
        grant_dma   = 1'b0;

        case (state_q)
            IDLE: begin
                // Core wins contention until DMA has waited through STARVE_LIMIT core grants.
                grant_core = core_req && !(dma_req && (scnt_q == SCNT_MAX));
                grant_dma  = dma_req && !grant_core;
                if (grant_core) begin
                    state_d     = ACCESS;
                    owner_d     = OWN_CORE;
                    mem_we_d    = core_we;
                    mem_addr_d  = core_addr;
                    mem_wdata_d = core_wdata;
                    if (!dma_req) begin
                        scnt_d = '0;
                    end else if (scnt_q != SCNT_MAX) begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end else if (grant_dma) begin
                    state_d     = ACCESS;
                    owner_d     = OWN_DMA;
                    mem_we_d    = dma_we;
                    mem_addr_d  = dma_addr;
                    mem_wdata_d = dma_wdata;
                    scnt_d      = '0;
                end
            end
            ACCESS: begin
                if (last_cycle) begin
                    state_d  = IDLE;
                    mem_we_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CORE;
            scnt_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            scnt_q      <= scnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_en     = in_access;
    assign busy       = in_access;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign dma_ack    = done && (owner_q == OWN_DMA);
    assign core_stall = core_req && !(done && (owner_q == OWN_CORE));
    assign core_rdata = mem_rdata;
    assign dma_rdata  = mem_rdata;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] dma_cnt_q, dma_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        dma_cnt_d   = dma_cnt_q;
        if (core_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (grant_dma && (dma_cnt_q != '1)) begin
            dma_cnt_d = dma_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            dma_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            dma_cnt_q   <= dma_cnt_d;
        end
    end

    assign stat_stall_cycles = stall_cnt_q;
    assign stat_dma_grants   = dma_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: drivers queue expected transfers, a monitor checks completions.
module tb_dmem_arbiter;

    localparam int WC = 3;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, dma_req, dma_we;
    logic [31:0] core_addr, core_wdata, dma_addr, dma_wdata;
    logic [31:0] core_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        core_stall, dma_ack, mem_en, mem_we, busy;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_stall_cycles;
    logic [15:0] stat_dma_grants;
    int          stall_ref;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(WC), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef DMEM_ARB_STATS_EN
        , .stat_stall_cycles(stat_stall_cycles), .stat_dma_grants(stat_dma_grants)
`endif
    );

    // Memory behind the arbiter, plus an independent reference image of its contents.
    logic [31:0] mem_model [0:255];
    logic [31:0] ref_mem   [0:255];
    assign mem_rdata = mem_model[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem_model[mem_addr[9:2]] <= mem_wdata;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } txn_t;

    txn_t core_q[$];
    txn_t dma_q[$];
    int   order_log[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   stall_run = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got event, expected none at %0t", nm, $time);
    endtask

    // Monitor: every completion pops the matching expectation.
    always @(negedge clk) begin
        txn_t t;
        if (!reset) begin
            stall_run = 0;
`ifdef DMEM_ARB_STATS_EN
            stall_ref = 0;
`endif
        end else begin
`ifdef DMEM_ARB_STATS_EN
            if (core_stall) stall_ref++;
`endif
            if (core_req && core_stall) stall_run++;
            if (core_req && !core_stall) begin
                order_log.push_back(0);
                if (core_q.size() == 0) begin
                    flag("core_unexpected_done");
                end else begin
                    t = core_q.pop_front();
                    check("core_mem_en", 32'(mem_en), 32'd1);
                    check("core_mem_we", 32'(mem_we), 32'(t.we));
                    check("core_mem_addr", mem_addr, t.addr);
                    if (t.we) check("core_mem_wdata", mem_wdata, t.wdata);
                    else      check("core_rdata", core_rdata, t.rdata);
                    if (t.lat >= 0) check("core_stall_len", 32'(stall_run), 32'(t.lat));
                end
                stall_run = 0;
            end
            if (dma_ack) begin
                order_log.push_back(1);
                if (dma_q.size() == 0) begin
                    flag("dma_unexpected_ack");
                end else begin
                    t = dma_q.pop_front();
                    check("dma_mem_we", 32'(mem_we), 32'(t.we));
                    check("dma_mem_addr", mem_addr, t.addr);
                    if (t.we) check("dma_mem_wdata", mem_wdata, t.wdata);
                    else      check("dma_rdata", dma_rdata, t.rdata);
                end
            end
        end
    end

    function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int lat);
        txn_t t;
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        t.rdata = we ? 32'd0 : ref_mem[addr[9:2]];
        t.lat   = lat;
        if (we) ref_mem[addr[9:2]] = wdata;
        return t;
    endfunction

    task automatic core_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int lat, input bit hold);
        int k;
        core_q.push_back(mk(we, addr, wdata, lat));
        core_we = we; core_addr = addr; core_wdata = wdata; core_req = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (core_stall && k < 200);
        if (core_stall) flag("core_timeout");
        @(posedge clk);
        #1;
        if (!hold) core_req = 1'b0;
    endtask

    task automatic dma_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
        int k;
        dma_q.push_back(mk(we, addr, wdata, -1));
        dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!dma_ack && k < 200);
        if (!dma_ack) flag("dma_timeout");
        @(posedge clk);
        #1;
        if (!hold) dma_req = 1'b0;
    endtask

    // Core works in words 0..63, DMA in words 64..127, so concurrent traffic never aliases.
    function automatic logic [31:0] core_rand_addr();
        return 32'($urandom_range(0, 63)) << 2;
    endfunction
    function automatic logic [31:0] dma_rand_addr();
        return 32'($urandom_range(64, 127)) << 2;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        for (int i = 0; i < 256; i++) begin
            mem_model[i] = $urandom;
            ref_mem[i]   = mem_model[i];
        end
        reset = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_core_stall", 32'(core_stall), 32'd1);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dma_ack", 32'(dma_ack), 32'd0);
        core_req = 1'b0;
        #1;
        check("rst_core_stall_idle", 32'(core_stall), 32'd0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        core_op(1'b1, 32'd100, 32'd25, WC, 1'b0);
        core_op(1'b0, 32'd100, 32'd0, WC, 1'b0);
        dma_op(1'b1, 32'd96, 32'd7, 1'b0);
        @(negedge clk);
        check("dma_after_busy", 32'(busy), 32'd0);
        check("dma_after_ack", 32'(dma_ack), 32'd0);
        dma_op(1'b0, 32'd96, 32'd0, 1'b0);
        core_op(1'b0, 32'd96, 32'd0, WC, 1'b0);

        // DMA read aborted by reset part-way through its wait states.
        dma_we = 1'b0; dma_addr = 32'd400; dma_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_mem_en", 32'(mem_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dma_ack", 32'(dma_ack), 32'd0);
        dma_req = 1'b0;
        @(negedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        // Contention: both held continuously, 8 core + 2 DMA transfers.
        base = order_log.size();
        fork
            for (int i = 0; i < 8; i++)
                core_op(1'($urandom_range(0, 1)), core_rand_addr(), $urandom, -1, i != 7);
            for (int j = 0; j < 2; j++)
                dma_op(1'($urandom_range(0, 1)), dma_rand_addr(), $urandom, j != 1);
        join
        for (int k = 0; k < 10; k++) begin
            int got;
            got = (base + k < order_log.size()) ? order_log[base + k] : -1;
            check("grant_order", 32'(got), ((k + 1) % (SL + 1) == 0) ? 32'd1 : 32'd0);
        end
`ifdef DMEM_ARB_STATS_EN
        check("stat_dma_grants", 32'(stat_dma_grants), 32'd2);
`endif

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 2))
                0: core_op(1'($urandom_range(0, 1)), core_rand_addr(), $urandom, WC, 1'b0);
                1: dma_op(1'($urandom_range(0, 1)), dma_rand_addr(), $urandom, 1'b0);
                default: fork
                    core_op(1'($urandom_range(0, 1)), core_rand_addr(), $urandom, -1, 1'b0);
                    dma_op(1'($urandom_range(0, 1)), dma_rand_addr(), $urandom, 1'b0);
                join
            endcase
        end

        repeat (3) @(negedge clk);
        check("core_q_drained", 32'(core_q.size()), 32'd0);
        check("dma_q_drained", 32'(dma_q.size()), 32'd0);
`ifdef DMEM_ARB_STATS_EN
        check("stat_stall_cycles", stat_stall_cycles, 32'(stall_ref));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
